// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clears the PEs, streams K operand
// steps with per-lane skew, drains the wavefront, then pulses done. Define SYSTOLIC_SEQ_CTRL_PERF_EN
// to add a saturating busy-cycle counter on perf_cycles.
module systolic_seq_ctrl #(
  parameter int N         = 4,
  parameter int REG_WIDTH = 4,
  parameter int KW        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [KW-1:0]          rd_addr,
  input  logic [N*REG_WIDTH-1:0] a_rd_data,
  input  logic [N*REG_WIDTH-1:0] b_rd_data,
  output logic                   arr_clr,
  output logic [N*REG_WIDTH-1:0] arr_a,
  output logic [N*REG_WIDTH-1:0] arr_b
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0]            perf_cycles
`endif
);

  localparam int DW = (2 * N > 2) ? $clog2(2 * N) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t        state_q, state_n;
  logic [KW-1:0] k_q, k_n;
  logic [KW-1:0] addr_n;
  logic [DW-1:0] drain_q, drain_n;
  logic          clr_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    k_n     = k_q;
    addr_n  = rd_addr;
    drain_n = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = CLEAR;
          k_n     = k_len;
        end
      end
      CLEAR: begin
        addr_n  = '0;
        drain_n = '0;
        state_n = (k_q != '0) ? FEED : DRAIN;
      end
      FEED: begin
        if (rd_addr == k_q - 1'b1) state_n = DRAIN;
        else                       addr_n  = rd_addr + 1'b1;
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_n = DONE;
        else                       drain_n = drain_q + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q as true flops
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= '0;
      rd_addr <= '0;
      drain_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      k_q     <= k_n;
      rd_addr <= addr_n;
      drain_q <= drain_n;
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
      rd_en   <= (state_n == FEED);
      clr_q   <= (state_n == CLEAR);
    end
  end

  assign arr_clr = reset | clr_q;

  // p0: operand memory returns data one cycle after rd_en
  logic         vld_p0;
  logic [N-1:0] vld_sk;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_sk <= '0;
    end else begin
      vld_p0    <= rd_en;
      vld_sk[0] <= vld_p0;
      for (int s = 1; s < N; s++) vld_sk[s] <= vld_sk[s-1];
    end
  end

  // Skew stages: lane i sits i+1 registers behind memory; validity is shared per depth
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [REG_WIDTH-1:0] a_p [0:i];
    logic [REG_WIDTH-1:0] b_p [0:i];

    always_ff @(posedge clk) begin
      a_p[0] <= a_rd_data[i*REG_WIDTH +: REG_WIDTH];
      b_p[0] <= b_rd_data[i*REG_WIDTH +: REG_WIDTH];
      for (int s = 1; s <= i; s++) begin
        a_p[s] <= a_p[s-1];
        b_p[s] <= b_p[s-1];
      end
    end

    assign arr_a[i*REG_WIDTH +: REG_WIDTH] = vld_sk[i] ? a_p[i] : '0;
    assign arr_b[i*REG_WIDTH +: REG_WIDTH] = vld_sk[i] ? b_p[i] : '0;
  end

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)                         perf_cycles <= '0;
    else if (state_q == IDLE && start) perf_cycles <= '0;
    else if (busy)                     perf_cycles <= sat_inc16(perf_cycles);
  end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: random operands, a memory and PE-array model, and per-cycle
// expectations derived from the run timing rules.
module tb_systolic_seq_ctrl;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int KW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            busy, done, rd_en, arr_clr;
  logic [KW-1:0]   rd_addr;
  logic [N*W-1:0]  a_rd_data, b_rd_data, arr_a, arr_b;
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  logic [15:0]     perf_cycles;
`endif

  systolic_seq_ctrl #(.N(N), .REG_WIDTH(W), .KW(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .arr_clr(arr_clr), .arr_a(arr_a), .arr_b(arr_b)
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int A [N][16];
  int B [16][N];
  int acc [N][N];
  int pa [N][N];
  int pb [N][N];
  int n_chk = 0;
  int n_pass = 0;

  // Operand memory: one-cycle read latency, garbage when not read
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      a_rd_data[i*W +: W] <= rd_en ? W'(A[i][rd_addr]) : W'($urandom);
      b_rd_data[i*W +: W] <= rd_en ? W'(B[rd_addr][i]) : W'($urandom);
    end
  end

  // Output-stationary PE array fed from the array edge
  always @(posedge clk) begin : pe_model
    int ain, bin;
    if (arr_clr) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = 0; pa[i][j] = 0; pb[i][j] = 0;
        end
    end else begin
      for (int i = N - 1; i >= 0; i--)
        for (int j = N - 1; j >= 0; j--) begin
          ain = (j == 0) ? int'(arr_a[i*W +: W]) : pa[i][j-1];
          bin = (i == 0) ? int'(arr_b[j*W +: W]) : pb[i-1][j];
          acc[i][j] += ain * bin;
          pa[i][j] = ain;
          pb[i][j] = bin;
        end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) begin
        A[i][k] = $urandom_range(0, 15);
        B[k][i] = $urandom_range(0, 15);
      end
  endtask

  task automatic fill_zero();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) begin
        A[i][k] = 0;
        B[k][i] = 0;
      end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the cycle after done
  task automatic run_checked(input int k, input bit noise, input string tag);
    int last, kk, c_exp;
    logic [N*W-1:0] ea, eb;
    logic [KW-1:0]  ead;
    logic e_done, e_clr, e_rden;
    k_len = KW'(k);
    start = 1'b1;
    last  = 2 + k + 2 * N;
    for (int r = 1; r <= last; r++) begin
      @(negedge clk);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        k_len = KW'($urandom);
      end else begin
        start = 1'b0;
      end
      e_done = (r == last);
      e_clr  = (r == 1);
      e_rden = (r >= 2 && r <= 1 + k);
      ead    = KW'(r - 2);
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
        kk = r - 4 - i;
        if (kk >= 0 && kk < k) begin
          ea[i*W +: W] = W'(A[i][kk]);
          eb[i*W +: W] = W'(B[kk][i]);
        end
      end
      n_chk++;
      if (busy !== 1'b1) $display("FAIL %s busy r=%0d got %b want 1", tag, r, busy);
      else n_pass++;
      n_chk++;
      if (done !== e_done) $display("FAIL %s done r=%0d got %b want %b", tag, r, done, e_done);
      else n_pass++;
      n_chk++;
      if (arr_clr !== e_clr) $display("FAIL %s arr_clr r=%0d got %b want %b", tag, r, arr_clr, e_clr);
      else n_pass++;
      n_chk++;
      if (rd_en !== e_rden) $display("FAIL %s rd_en r=%0d got %b want %b", tag, r, rd_en, e_rden);
      else n_pass++;
      if (e_rden) begin
        n_chk++;
        if (rd_addr !== ead) $display("FAIL %s rd_addr r=%0d got %0d want %0d", tag, r, rd_addr, ead);
        else n_pass++;
      end
      n_chk++;
      if (arr_a !== ea) $display("FAIL %s arr_a r=%0d got %h want %h", tag, r, arr_a, ea);
      else n_pass++;
      n_chk++;
      if (arr_b !== eb) $display("FAIL %s arr_b r=%0d got %h want %h", tag, r, arr_b, eb);
      else n_pass++;
    end
    start = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c_exp = 0;
        for (int q = 0; q < k; q++) c_exp += A[i][q] * B[q][j];
        n_chk++;
        if (acc[i][j] !== c_exp) $display("FAIL %s C[%0d][%0d] got %0d want %0d", tag, i, j, acc[i][j], c_exp);
        else n_pass++;
      end
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0)
      $display("FAIL %s post_idle got busy=%b done=%b rd_en=%b want 0 0 0", tag, busy, done, rd_en);
    else n_pass++;
    n_chk++;
    if (arr_a !== '0 || arr_b !== '0)
      $display("FAIL %s post_lanes got %h/%h want 0/0", tag, arr_a, arr_b);
    else n_pass++;
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    n_chk++;
    if (perf_cycles !== 16'(k + 2 + 2 * N))
      $display("FAIL %s perf_cycles got %0d want %0d", tag, perf_cycles, k + 2 + 2 * N);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || rd_addr !== '0)
      $display("FAIL reset_ctrl got busy=%b done=%b rd_en=%b rd_addr=%0d want 0", busy, done, rd_en, rd_addr);
    else n_pass++;
    n_chk++;
    if (arr_a !== '0 || arr_b !== '0)
      $display("FAIL reset_lanes got %h/%h want 0/0", arr_a, arr_b);
    else n_pass++;
    n_chk++;
    if (arr_clr !== 1'b1) $display("FAIL reset_arr_clr got %b want 1", arr_clr);
    else n_pass++;
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    n_chk++;
    if (perf_cycles !== 16'd0) $display("FAIL reset_perf got %0d want 0", perf_cycles);
    else n_pass++;
`endif
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    while (cyc < 10) @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) begin
        A[i][k] = (i + k) % 16;
        B[k][i] = (k + i + 1) % 16;
      end
    run_checked(4, 1'b0, "ramp");
  endtask

  task automatic test_skew();
    fill_zero();
    for (int i = 0; i < N; i++) begin
      A[i][0] = i + 1;
      B[0][i] = i + 1;
    end
    @(negedge clk);
    run_checked(1, 1'b0, "skew");
  endtask

  task automatic test_k_zero();
    fill_random();
    @(negedge clk);
    run_checked(0, 1'b0, "k_zero");
  endtask

  task automatic test_start_noise();
    fill_random();
    @(negedge clk);
    run_checked(4, 1'b1, "noise");
  endtask

  task automatic test_reset_mid_drain();
    fill_random();
    @(negedge clk);
    k_len = 4'd4;
    start = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (arr_clr !== 1'b1) $display("FAIL midreset_clr_now got %b want 1", arr_clr);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (arr_clr !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0)
      $display("FAIL midreset_ctrl got clr=%b busy=%b done=%b rd_en=%b want 1 0 0 0", arr_clr, busy, done, rd_en);
    else n_pass++;
    n_chk++;
    if (arr_a !== '0 || arr_b !== '0) $display("FAIL midreset_lanes got %h/%h want 0/0", arr_a, arr_b);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL midreset_quiet c=%0d got done=%b busy=%b want 0 0", c, done, busy);
      else n_pass++;
    end
    fill_random();
    run_checked(5, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    fill_random();
    @(negedge clk);
    run_checked(3, 1'b0, "b2b_first");
    fill_random();
    run_checked(5, 1'b0, "b2b_second");
  endtask

  task automatic test_random_runs();
    for (int n = 0; n < 3; n++) begin
      fill_random();
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_checked($urandom_range(0, 15), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_skew();
    test_k_zero();
    test_start_noise();
    test_reset_mid_drain();
    test_back_to_back();
    test_random_runs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
